pipe_alu: RTL and testbench

PIPE_ALU -- requirements
Module: pipe_alu

---
 rtl/pipe_alu.sv | 170 +++++++++++++++++
 tb/tb_pipe_alu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_alu.sv
`default_nettype none
// ============================================================================
// Module   : pipe_alu
// Purpose  : Valid/ready ALU with a single-entry registered output and an
//            iterative shift-add multiplier (one multiplier bit per cycle).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             illegal,
  output logic             busy
);

  localparam int         c_CNT_W  = $clog2(WIDTH + 1);
  localparam logic [3:0] c_OP_ADD = 4'b0000;
  localparam logic [3:0] c_OP_SUB = 4'b0001;
  localparam logic [3:0] c_OP_AND = 4'b0010;
  localparam logic [3:0] c_OP_OR  = 4'b0011;
  localparam logic [3:0] c_OP_XOR = 4'b0100;
  localparam logic [3:0] c_OP_NOT = 4'b0101;
  localparam logic [3:0] c_OP_SL1 = 4'b0110;
  localparam logic [3:0] c_OP_SR1 = 4'b0111;
  localparam logic [3:0] c_OP_SLT = 4'b1000;
  localparam logic [3:0] c_OP_MUL = 4'b1001;
  localparam logic [3:0] c_OP_SHL = 4'b1010;
  localparam logic [3:0] c_OP_ASR = 4'b1011;

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_e;

  state_e               state_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     result_q;
  logic                 overflow_q, negative_q, zero_q, carry_q, illegal_q;
  logic [2*WIDTH-1:0]   acc_q, mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [c_CNT_W-1:0]   cnt_q;

  logic [WIDTH:0]       sum_ext, dif_ext;
  logic [WIDTH-1:0]     alu_res_d;
  logic                 alu_ovf_d, alu_cy_d, alu_ill_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic                 mul_last;
  logic                 accept;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == MUL);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign negative  = negative_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign illegal   = illegal_q;

  // Single-cycle datapath; MUL is handled by the iterative unit below.
  always_comb begin
    sum_ext   = {1'b0, A} + {1'b0, B};
    dif_ext   = {1'b0, A} - {1'b0, B};
    alu_res_d = '0;
    alu_ovf_d = 1'b0;
    alu_cy_d  = 1'b0;
    alu_ill_d = 1'b0;
    case (opcode)
      c_OP_ADD: begin
        alu_res_d = sum_ext[WIDTH-1:0];
        alu_cy_d  = sum_ext[WIDTH];
        alu_ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      c_OP_SUB: begin
        alu_res_d = dif_ext[WIDTH-1:0];
        alu_cy_d  = dif_ext[WIDTH];
        alu_ovf_d = (A[WIDTH-1] != B[WIDTH-1]) && (dif_ext[WIDTH-1] != A[WIDTH-1]);
      end
      c_OP_AND: alu_res_d = A & B;
      c_OP_OR:  alu_res_d = A | B;
      c_OP_XOR: alu_res_d = A ^ B;
      c_OP_NOT: alu_res_d = ~A;
      c_OP_SL1: begin
        alu_res_d = {A[WIDTH-2:0], 1'b0};
        alu_cy_d  = A[WIDTH-1];
      end
      c_OP_SR1: alu_res_d = {1'b0, A[WIDTH-1:1]};
      c_OP_SLT: alu_res_d = {{(WIDTH-1){1'b0}}, (A < B)};
      c_OP_MUL: alu_res_d = '0;
      c_OP_SHL: alu_res_d = A << B[SHW-1:0];
      c_OP_ASR: alu_res_d = $signed(A) >>> B[SHW-1:0];
      default:  alu_ill_d = 1'b1;
    endcase
  end

  assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
  assign mul_last = (cnt_q == c_CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && (opcode == c_OP_MUL)) begin
            // Output slot is free (or being consumed now), so it stays empty during MUL.
            state_q     <= MUL;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= {{WIDTH{1'b0}}, A};
            mplier_q    <= B;
            cnt_q       <= '0;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res_d;
            overflow_q  <= alu_ovf_d;
            negative_q  <= alu_res_d[WIDTH-1];
            zero_q      <= (alu_res_d == '0);
            carry_q     <= alu_cy_d;
            illegal_q   <= alu_ill_d;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + c_CNT_W'(1);
          if (mul_last) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
            result_q    <= acc_d[WIDTH-1:0];
            overflow_q  <= |acc_d[2*WIDTH-1:WIDTH];
            negative_q  <= acc_d[WIDTH-1];
            zero_q      <= (acc_d[WIDTH-1:0] == '0);
            carry_q     <= 1'b0;
            illegal_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_alu
// Purpose  : Directed scoreboard bench for pipe_alu (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_alu;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] A, B, result;
  logic [3:0] opcode;
  logic       overflow, negative, zero, carry, illegal, busy;

  typedef struct {
    logic [3:0] op;
    logic [7:0] res;
    logic [4:0] flg;   // {overflow, negative, zero, carry, illegal}
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   took;

  always #5 clk = ~clk;

  pipe_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .negative(negative), .zero(zero),
    .carry(carry), .illegal(illegal), .busy(busy)
  );

  function automatic exp_t model(logic [3:0] op, logic [7:0] a, logic [7:0] b);
    exp_t e;
    int ia, ib, sa, sb, r, sh;
    logic ovf, cy, ill;
    ia = int'(a); ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    sh = int'(b[2:0]);
    ovf = 1'b0; cy = 1'b0; ill = 1'b0; r = 0;
    case (op)
      4'd0: begin r = ia + ib; cy = (r > 255); ovf = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin r = ia - ib; cy = (ia < ib); ovf = (sa - sb > 127) || (sa - sb < -128); end
      4'd2: r = ia & ib;
      4'd3: r = ia | ib;
      4'd4: r = ia ^ ib;
      4'd5: r = 255 - ia;
      4'd6: begin r = ia * 2; cy = a[7]; end
      4'd7: r = ia / 2;
      4'd8: r = (ia < ib) ? 1 : 0;
      4'd9: begin r = ia * ib; ovf = (r > 255); end
      4'd10: r = ia << sh;
      4'd11: r = sa >>> sh;
      default: begin r = 0; ill = 1'b1; end
    endcase
    e.op  = op;
    e.res = r[7:0];
    e.flg = {ovf, e.res[7], (e.res == 8'd0), cy, ill};
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample at negedge (pop before push), then step past the posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {24'd0, result}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("result op=%0d", e.op), {24'd0, result}, {24'd0, e.res});
        check($sformatf("flags op=%0d", e.op),
              {27'd0, overflow, negative, zero, carry, illegal}, {27'd0, e.flg});
      end
    end
    took = 1'b0;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(opcode, A, B));
      took = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [3:0] op, logic [7:0] a, logic [7:0] b);
    int k;
    opcode = op; A = a; B = b; in_valid = 1'b1;
    k = 0;
    took = 1'b0;
    while (!took && k < 40) begin
      cycle();
      k++;
    end
    if (!took) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      cycle();
      k++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  logic [7:0] r0;
  logic [4:0] f0;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; opcode = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {overflow, negative, zero, carry, illegal}, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);

    issue(4'd0, 8'd50, 8'd20);
    check("single_latency", out_valid, 1);
    issue(4'd1, 8'd20, 8'd20);
    issue(4'd0, 8'd100, 8'd100);
    issue(4'd1, 8'd5, 8'd10);
    issue(4'd11, 8'h90, 8'd3);
    issue(4'd10, 8'h0F, 8'd4);
    issue(4'd8, 8'd5, 8'd10);
    issue(4'd14, 8'h33, 8'h44);
    issue(4'd2, 8'hF0, 8'h3C);
    issue(4'd3, 8'hA0, 8'h05);
    issue(4'd4, 8'hFF, 8'h0F);
    issue(4'd5, 8'h5A, 8'h00);
    issue(4'd6, 8'h81, 8'h00);
    issue(4'd7, 8'h81, 8'h00);
    issue(4'd15, 8'h00, 8'h00);
    drain();

    // MUL timing: busy for exactly 8 cycles, result lands on the 8th edge.
    issue(4'd9, 8'd15, 8'd17);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mul_busy c%0d", i), busy, 1);
      check($sformatf("mul_in_ready c%0d", i), in_ready, 0);
      check($sformatf("mul_out_valid c%0d", i), out_valid, 0);
      cycle();
    end
    check("mul_done_valid", out_valid, 1);
    check("mul_done_busy", busy, 0);
    issue(4'd9, 8'd16, 8'd16);
    drain();

    // Backpressure: result held, pending request not captured, then back-to-back.
    out_ready = 1'b0;
    issue(4'd0, 8'd3, 8'd4);
    r0 = result;
    f0 = {overflow, negative, zero, carry, illegal};
    check("bp_first", {24'd0, r0}, 32'd7);
    opcode = 4'd0; A = 8'd9; B = 8'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("bp_hold_res c%0d", i), result, r0);
      check($sformatf("bp_hold_flg c%0d", i), {overflow, negative, zero, carry, illegal}, f0);
      check($sformatf("bp_in_ready c%0d", i), in_ready, 0);
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("b2b_valid", out_valid, 1);
    drain();

    // Reset three cycles into a MUL aborts it.
    issue(4'd9, 8'd7, 8'd9);
    repeat (3) cycle();
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    exp_q.delete();
    repeat (2) cycle();
    rst_n = 1'b1;
    check("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) cycle();
    check("no_mul_result", out_valid, 0);
    issue(4'd0, 8'd1, 8'd2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
